// File: rtl/frame_proc_sequencer.sv
// Full-frame pass sequencer: sweeps the image ROM, streams pixels through the ALU, writes results to the frame buffer.
// Optional MODE_AUTO_START_EN: a mode-switch change while idle launches a pass like a start pulse.
module frame_proc_sequencer #(
   parameter int unsigned H_RES         = 640,
   parameter int unsigned V_RES         = 480,
   parameter int unsigned ADDR_W        = 19,
   parameter int unsigned PIX_W         = 8,
   parameter int unsigned DRAIN_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        mode,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [PIX_W-1:0]  rom_q,
   output logic [3:0]        alu_mode,
   output logic [PIX_W-1:0]  alu_pixel_in,
   output logic              alu_in_valid,
   input  logic [PIX_W-1:0]  alu_pixel_out,
   input  logic              alu_out_valid,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [PIX_W-1:0]  fb_data
);

   localparam int unsigned       N_PIX     = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] N_ADDR    = ADDR_W'(N_PIX);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
   localparam int unsigned       IDLE_W    = $clog2(DRAIN_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic                err_q, err_d;
   logic [3:0]          alu_mode_q, alu_mode_d;
   logic                valid_q;
   logic                issue;
   logic                launch;
   logic                fb_we_q, fb_we_d;
   logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
   logic [PIX_W-1:0]    fb_data_q, fb_data_d;

`ifdef MODE_AUTO_START_EN
   assign launch = start | (mode != alu_mode_q);
`else
   assign launch = start;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      rd_cnt_d   = rd_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      idle_d     = idle_q;
      err_d      = err_q;
      alu_mode_d = alu_mode_q;
      issue      = 1'b0;
      fb_we_d    = 1'b0;
      fb_addr_d  = fb_addr_q;
      fb_data_d  = fb_data_q;

      // Write-back runs alongside fetch; surplus results past the frame end are dropped.
      if ((state_q == S_FETCH || state_q == S_DRAIN) && alu_out_valid && wr_cnt_q < N_ADDR) begin
         fb_we_d   = 1'b1;
         fb_addr_d = wr_cnt_q;
         fb_data_d = alu_pixel_out;
         wr_cnt_d  = wr_cnt_q + 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (launch) begin
               alu_mode_d = mode;
               rd_cnt_d   = '0;
               wr_cnt_d   = '0;
               idle_d     = '0;
               err_d      = 1'b0;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: begin
            issue    = 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
            idle_d   = '0;
            if (rd_cnt_q == LAST_ADDR) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            idle_d = alu_out_valid ? '0 : idle_q + 1'b1;
            if (wr_cnt_q == N_ADDR) begin
               state_d = S_DONE;
            end else if (idle_q == IDLE_W'(DRAIN_TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         idle_q     <= '0;
         err_q      <= 1'b0;
         alu_mode_q <= '0;
         valid_q    <= 1'b0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         idle_q     <= idle_d;
         err_q      <= err_d;
         alu_mode_q <= alu_mode_d;
         valid_q    <= issue;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
      end
   end

   // The issue strobe is delayed one cycle to line up with the registered ROM output.
   assign alu_in_valid = valid_q;
   assign alu_pixel_in = rom_q;
   assign rom_addr     = rd_cnt_q;
   assign alu_mode     = alu_mode_q;
   assign busy         = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign done         = (state_q == S_DONE);
   assign err          = err_q;
   assign fb_we        = fb_we_q;
   assign fb_addr      = fb_addr_q;
   assign fb_data      = fb_data_q;

endmodule

// File: tb/tb_frame_proc_sequencer.sv
// Scoreboard bench for frame_proc_sequencer on a 4x2 frame with a registered ROM and a 2-cycle pass-through ALU.
module tb_frame_proc_sequencer;

   localparam int N      = 8;
   localparam int ADDR_W = 19;
   localparam int PIX_W  = 8;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [PIX_W-1:0]  data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [3:0]        mode;
   logic              busy, done, err;
   logic [ADDR_W-1:0] rom_addr;
   logic [PIX_W-1:0]  rom_q;
   logic [3:0]        alu_mode;
   logic [PIX_W-1:0]  alu_pixel_in;
   logic              alu_in_valid;
   logic [PIX_W-1:0]  alu_pixel_out;
   logic              alu_out_valid;
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   logic [PIX_W-1:0]  fb_data;

   int          checks   = 0;
   int          failures = 0;
   wr_t         exp_q[$];
   logic [7:0]  rom_mem [16];
   int          limit;
   logic        inject;

   logic              v1, v2;
   logic [PIX_W-1:0]  p1, p2;
   int                delivered;

   frame_proc_sequencer #(
      .H_RES(4), .V_RES(2), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .DRAIN_TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .busy(busy), .done(done), .err(err),
      .rom_addr(rom_addr), .rom_q(rom_q),
      .alu_mode(alu_mode), .alu_pixel_in(alu_pixel_in), .alu_in_valid(alu_in_valid),
      .alu_pixel_out(alu_pixel_out), .alu_out_valid(alu_out_valid),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
   );

   always #5 clk = ~clk;

   // Registered ROM, one-cycle read latency.
   always @(posedge clk) rom_q <= rom_mem[rom_addr[3:0]];

   // Pass-through ALU with two-cycle latency; stops producing after 'limit' results per pass.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1 <= 1'b0; v2 <= 1'b0; p1 <= '0; p2 <= '0; delivered <= 0;
      end else begin
         v1 <= alu_in_valid; p1 <= alu_pixel_in;
         v2 <= v1;           p2 <= p1;
         if (!busy) delivered <= 0;
         else if (v2 && delivered < limit) delivered <= delivered + 1;
      end
   end
   assign alu_out_valid = (v2 && delivered < limit) || inject;
   assign alu_pixel_out = p2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every frame-buffer write must match the next expected write.
   always @(negedge clk) begin
      wr_t e;
      if (rst && fb_we) begin
         if (exp_q.size() == 0) begin
            check("fb_we_unexpected", 32'(fb_we), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("fb_addr", 32'(fb_addr), 32'(e.addr));
            check("fb_data", 32'(fb_data), 32'(e.data));
         end
      end
   end

   task automatic reset_vals(input string tag);
      check({tag, "_busy"},         32'(busy),         0);
      check({tag, "_done"},         32'(done),         0);
      check({tag, "_err"},          32'(err),          0);
      check({tag, "_rom_addr"},     32'(rom_addr),     0);
      check({tag, "_alu_mode"},     32'(alu_mode),     0);
      check({tag, "_alu_in_valid"}, 32'(alu_in_valid), 0);
      check({tag, "_fb_we"},        32'(fb_we),        0);
      check({tag, "_fb_addr"},      32'(fb_addr),      0);
      check({tag, "_fb_data"},      32'(fb_data),      0);
   endtask

   task automatic run_pass(input logic [3:0] m, input int n_res, input bit repulse,
                           input bit tail_inject, input bit auto_go);
      int done_cnt;
      int done_k;
      limit = n_res;
      for (int i = 0; i < N; i++) rom_mem[i] = 8'($urandom);
      for (int i = 0; i < n_res && i < N; i++) exp_q.push_back('{addr: ADDR_W'(i), data: rom_mem[i]});
      @(negedge clk);
      mode = m;
      if (!auto_go) start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      done_cnt = 0;
      done_k   = 0;
      for (int k = 1; k <= 400; k++) begin
         if (k == 1) begin
            check("busy_rise", 32'(busy), 1);
            check("err_cleared", 32'(err), 0);
         end
         if (k <= N) check("rom_addr", 32'(rom_addr), 32'(k - 1));
         if (k <= N + 2) check("alu_in_valid", 32'(alu_in_valid), 32'(k >= 2 && k <= N + 1));
         if (k >= 2 && k <= N + 1) check("alu_pixel_in", 32'(alu_pixel_in), 32'(rom_mem[k - 2]));
         if (busy) check("alu_mode_held", 32'(alu_mode), 32'(m));
         if (repulse) begin
            if (k == 3) begin start = 1'b1; mode = ~m; end
            if (k == 4) start = 1'b0;
            if (k == 5) mode = m;
         end
         if (tail_inject) begin
            if (k >= 13 && k <= 15) check("fb_we_after_last", 32'(fb_we), 0);
            if (k == 12) inject = 1'b1;
            if (k == 15) inject = 1'b0;
         end
         if (done) begin done_cnt++; done_k = k; end
         if (done_k != 0 && k >= done_k + 2) break;
         @(negedge clk);
      end
      inject = 1'b0;
      check("done_pulses", 32'(done_cnt), 1);
      check("err_after_pass", 32'(err), 32'(n_res < N));
      check("writes_outstanding", 32'(exp_q.size()), 0);
      check("busy_after_pass", 32'(busy), 0);
   endtask

   task automatic reset_abort(input logic [3:0] m);
      limit = N;
      for (int i = 0; i < N; i++) rom_mem[i] = 8'($urandom);
      for (int i = 0; i < N; i++) exp_q.push_back('{addr: ADDR_W'(i), data: rom_mem[i]});
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_rom_addr", 32'(rom_addr), 4);
      check("abort_fb_we_pre", 32'(fb_we), 1);
      #2 rst = 1'b0;
      #1 reset_vals("abort");
      exp_q.delete();
      mode = 4'h0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; mode = 4'h0; inject = 1'b0; limit = N;
      for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;
      #2 reset_vals("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run_pass(4'h3, N, 1'b0, 1'b0, 1'b0);
      run_pass(4'h3, 6, 1'b0, 1'b0, 1'b0);
      run_pass(4'h3, N, 1'b1, 1'b0, 1'b0);
      reset_abort(4'h9);
      run_pass(4'h6, N, 1'b0, 1'b0, 1'b0);
      repeat (3) run_pass(4'($urandom), N, 1'b0, 1'b1, 1'b0);

      @(negedge clk);
      inject = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("idle_inject_fb_we", 32'(fb_we), 0);
      end
      inject = 1'b0;

      run_pass(4'h0, N, 1'b0, 1'b0, 1'b0);
`ifdef MODE_AUTO_START_EN
      run_pass(4'h5, N, 1'b0, 1'b0, 1'b1);
`else
      @(negedge clk);
      mode = 4'h5;
      repeat (4) begin
         @(negedge clk);
         check("no_auto_start", 32'(busy), 0);
      end
      mode = 4'h0;
`endif
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
